accel_job_seq: RTL and testbench

ACCEL_JOB_SEQ -- requirements
Module: accel_job_seq

---
 rtl/accel_pkg.sv | 36 +++
 rtl/accel_wr_port.sv | 33 +++
 rtl/accel_job_seq.sv | 188 ++++++++++++++++++
 tb/tb_accel_job_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared state codes, write-select encodings and config field widths for the accelerator job
// sequencer.
package accel_pkg;

    localparam int DATA_W   = 18;
    localparam int ADDR_W   = 16;
    localparam int DIM_W    = 8;
    localparam int DEPTH_W  = 9;
    localparam int STRIDE_W = 3;
    localparam int HALF_W   = 2;
    localparam int FLEN_W   = 13;
    localparam int BIAS_W   = 18;
    localparam int TOTAL_W  = 25;

    localparam logic [3:0] S_DIM    = 4'd0;
    localparam logic [3:0] S_DEPTH  = 4'd1;
    localparam logic [3:0] S_IMG    = 4'd2;
    localparam logic [3:0] S_STRIDE = 4'd3;
    localparam logic [3:0] S_HALF   = 4'd4;
    localparam logic [3:0] S_FLEN   = 4'd5;
    localparam logic [3:0] S_BIAS   = 4'd6;
    localparam logic [3:0] S_FILT   = 4'd7;
    localparam logic [3:0] S_RUN    = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;
    localparam logic [3:0] S_ERR    = 4'd10;

    localparam logic [1:0] WR_SEL_IMG  = 2'd0;
    localparam logic [1:0] WR_SEL_FILT = 2'd1;

    // Full-width product so no depth*dim*dim combination can wrap.
    function automatic logic [TOTAL_W-1:0] img_words(input logic [DEPTH_W-1:0] depth,
                                                     input logic [DIM_W-1:0]   dim);
        return TOTAL_W'(depth) * TOTAL_W'(dim) * TOTAL_W'(dim);
    endfunction

endpackage

// File: rtl/accel_wr_port.sv
// Registered accelerator write port: one write per transfer strobe, idle otherwise.
module accel_wr_port
    import accel_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic [1:0]        wr_sel
);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr <= '0;
            wr_data <= '0;
            wr_en   <= 1'b0;
            wr_sel  <= WR_SEL_IMG;
        end else begin
            wr_en <= strobe;
            if (strobe) begin
                wr_addr <= addr;
                wr_data <= data;
                wr_sel  <= sel;
            end
        end
    end

endmodule

// File: rtl/accel_job_seq.sv
// Job sequencer: parses the header/image/filter word stream, loads the accelerator memories,
// then runs the accelerator until done, timeout, abort or error.
module accel_job_seq
    import accel_pkg::*;
#(
    parameter int unsigned RUN_TIMEOUT   = 1048576,
    parameter int unsigned MAX_IMG_WORDS = 65536
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                abort,
    input  logic                job_clr,
    output logic [DIM_W-1:0]    image_dim,
    output logic [DEPTH_W-1:0]  image_depth,
    output logic [STRIDE_W-1:0] filter_stride,
    output logic [HALF_W-1:0]   filter_halfsize,
    output logic [FLEN_W-1:0]   filter_length,
    output logic [BIAS_W-1:0]   filter_bias,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_en,
    output logic [1:0]          wr_sel,
    output logic                accel_run,
    input  logic                accel_done,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [3:0]          state
);

    logic [3:0]          state_q, state_d;
    logic [TOTAL_W-1:0]  cnt_q, cnt_d;
    logic [31:0]         run_cnt_q, run_cnt_d;
    logic [TOTAL_W-1:0]  img_total_q;
    logic [TOTAL_W-1:0]  img_calc;
    logic                accel_run_q;
    logic                xfer;
    logic                wr_strobe;
    logic [1:0]          wr_sel_d;
    logic [DIM_W-1:0]    image_dim_q;
    logic [DEPTH_W-1:0]  image_depth_q;
    logic [STRIDE_W-1:0] filter_stride_q;
    logic [HALF_W-1:0]   filter_halfsize_q;
    logic [FLEN_W-1:0]   filter_length_q;
    logic [BIAS_W-1:0]   filter_bias_q;

    assign in_ready = (state_q <= S_FILT);
    assign xfer     = in_valid && in_ready;
    assign img_calc = img_words(in_data[DEPTH_W-1:0], image_dim_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_cnt_d = run_cnt_q;
        wr_strobe = 1'b0;
        wr_sel_d  = WR_SEL_IMG;
        if (abort) begin
            state_d   = S_DIM;
            cnt_d     = '0;
            run_cnt_d = '0;
        end else begin
            case (state_q)
                S_DIM:    if (xfer) state_d = S_DEPTH;
                S_DEPTH: begin
                    if (xfer) begin
                        cnt_d = '0;
                        if (img_calc == '0 || img_calc > TOTAL_W'(MAX_IMG_WORDS)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_IMG;
                        end
                    end
                end
                S_IMG: begin
                    if (xfer) begin
                        wr_strobe = 1'b1;
                        if ((cnt_q + TOTAL_W'(1)) == img_total_q) begin
                            state_d = S_STRIDE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + TOTAL_W'(1);
                        end
                    end
                end
                S_STRIDE: if (xfer) state_d = S_HALF;
                S_HALF:   if (xfer) state_d = S_FLEN;
                S_FLEN: begin
                    if (xfer) state_d = (in_data[FLEN_W-1:0] == '0) ? S_ERR : S_BIAS;
                end
                S_BIAS: begin
                    if (xfer) begin
                        state_d = S_FILT;
                        cnt_d   = '0;
                    end
                end
                S_FILT: begin
                    if (xfer) begin
                        wr_strobe = 1'b1;
                        wr_sel_d  = WR_SEL_FILT;
                        if ((cnt_q + TOTAL_W'(1)) == TOTAL_W'(filter_length_q)) begin
                            state_d   = S_RUN;
                            cnt_d     = '0;
                            run_cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + TOTAL_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (accel_done) begin
                        state_d = S_DONE;
                    end else if (run_cnt_q >= RUN_TIMEOUT) begin
                        state_d = S_ERR;
                    end else begin
                        run_cnt_d = run_cnt_q + 32'd1;
                    end
                end
                S_DONE, S_ERR: if (job_clr) state_d = S_DIM;
                default:  state_d = S_DIM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_DIM;
            cnt_q             <= '0;
            run_cnt_q         <= '0;
            img_total_q       <= '0;
            accel_run_q       <= 1'b0;
            image_dim_q       <= '0;
            image_depth_q     <= '0;
            filter_stride_q   <= '0;
            filter_halfsize_q <= '0;
            filter_length_q   <= '0;
            filter_bias_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_cnt_q   <= run_cnt_d;
            // One cycle late on entry keeps the run release clear of the last filter write.
            accel_run_q <= (state_q == S_RUN) && (state_d == S_RUN);
            if (xfer && !abort) begin
                case (state_q)
                    S_DIM:    image_dim_q <= in_data[DIM_W-1:0];
                    S_DEPTH: begin
                        image_depth_q <= in_data[DEPTH_W-1:0];
                        img_total_q   <= img_calc;
                    end
                    S_STRIDE: filter_stride_q   <= in_data[STRIDE_W-1:0];
                    S_HALF:   filter_halfsize_q <= in_data[HALF_W-1:0];
                    S_FLEN:   filter_length_q   <= in_data[FLEN_W-1:0];
                    S_BIAS:   filter_bias_q     <= in_data[BIAS_W-1:0];
                    default:  ;
                endcase
            end
        end
    end

    accel_wr_port u_wr_port (
        .clk     (clk),
        .rst     (rst),
        .strobe  (wr_strobe),
        .addr    (cnt_q[ADDR_W-1:0]),
        .data    (in_data),
        .sel     (wr_sel_d),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel)
    );

    assign image_dim       = image_dim_q;
    assign image_depth     = image_depth_q;
    assign filter_stride   = filter_stride_q;
    assign filter_halfsize = filter_halfsize_q;
    assign filter_length   = filter_length_q;
    assign filter_bias     = filter_bias_q;
    assign accel_run       = accel_run_q;
    assign state           = state_q;
    assign busy            = (state_q != S_DIM) && (state_q <= S_RUN);
    assign done            = (state_q == S_DONE);
    assign err             = (state_q == S_ERR);

endmodule

// File: tb/tb_accel_job_seq.sv
// Directed and randomized job streams checked against a word-level model of the job format.
module tb_accel_job_seq;

    localparam int RUN_TIMEOUT = 100;
    localparam int MAX_IMG     = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        abort;
    logic        job_clr;
    logic [7:0]  image_dim;
    logic [8:0]  image_depth;
    logic [2:0]  filter_stride;
    logic [1:0]  filter_halfsize;
    logic [12:0] filter_length;
    logic [17:0] filter_bias;
    logic [15:0] wr_addr;
    logic [17:0] wr_data;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic        accel_run;
    logic        accel_done;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  state;

    always #5 clk = ~clk;

    accel_job_seq #(
        .RUN_TIMEOUT   (RUN_TIMEOUT),
        .MAX_IMG_WORDS (MAX_IMG)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .abort           (abort),
        .job_clr         (job_clr),
        .image_dim       (image_dim),
        .image_depth     (image_depth),
        .filter_stride   (filter_stride),
        .filter_halfsize (filter_halfsize),
        .filter_length   (filter_length),
        .filter_bias     (filter_bias),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_en           (wr_en),
        .wr_sel          (wr_sel),
        .accel_run       (accel_run),
        .accel_done      (accel_done),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .state           (state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int overlap = 0;
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];
    // Model of the config fields as last written by the stream.
    int m_dim = 0, m_depth = 0, m_stride = 0, m_half = 0, m_len = 0, m_bias = 0;

    always @(negedge clk) begin
        if (wr_en) got_q.push_back({wr_sel, wr_addr, wr_data});
        if (wr_en && accel_run) overlap++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cfg(input string tag);
        check({tag, "_dim"},    36'(image_dim),       36'(m_dim));
        check({tag, "_depth"},  36'(image_depth),     36'(m_depth));
        check({tag, "_stride"}, 36'(filter_stride),   36'(m_stride));
        check({tag, "_half"},   36'(filter_halfsize), 36'(m_half));
        check({tag, "_len"},    36'(filter_length),   36'(m_len));
        check({tag, "_bias"},   36'(filter_bias),     36'(m_bias));
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 36'(got_q.size()), 36'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [17:0] d, input int gap);
        int idle;
        idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (idle) tick();
        check("in_ready", 36'(in_ready), 36'(1));
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 18'($urandom);
    endtask

    task automatic load_job(input logic [17:0] dim_w, input logic [17:0] depth_w,
                            input logic [17:0] stride_w, input logic [17:0] half_w,
                            input logic [17:0] len_w, input logic [17:0] bias_w,
                            input int gap, input bit seq, output bit ok);
        int total;
        logic [17:0] d;
        ok = 1'b0;
        send(dim_w, gap);
        m_dim = int'(dim_w[7:0]);
        send(depth_w, gap);
        m_depth = int'(depth_w[8:0]);
        total = m_dim * m_dim * m_depth;
        if (total == 0 || total > MAX_IMG) return;
        for (int i = 0; i < total; i++) begin
            d = seq ? 18'(i + 1) : 18'($urandom);
            send(d, gap);
            exp_q.push_back({2'd0, 16'(i), d});
        end
        send(stride_w, gap);
        m_stride = int'(stride_w[2:0]);
        send(half_w, gap);
        m_half = int'(half_w[1:0]);
        send(len_w, gap);
        m_len = int'(len_w[12:0]);
        if (m_len == 0) return;
        send(bias_w, gap);
        m_bias = int'(bias_w);
        for (int i = 0; i < m_len; i++) begin
            d = seq ? 18'(i + 7) : 18'($urandom);
            send(d, gap);
            exp_q.push_back({2'd1, 16'(i), d});
        end
        ok = 1'b1;
    endtask

    task automatic wait_run();
        int k = 0;
        while (!accel_run && k < 6) begin
            tick();
            k++;
        end
        check("run_rise", 36'(accel_run), 36'(1));
        check("run_no_wr", 36'(wr_en), 36'(0));
        check("run_busy", 36'(busy), 36'(1));
    endtask

    task automatic clear_job();
        job_clr = 1'b1;
        tick();
        job_clr = 1'b0;
        check("clr_state", 36'(state), 36'(0));
        check("clr_done", 36'(done), 36'(0));
        check("clr_err", 36'(err), 36'(0));
    endtask

    task automatic finish_err(input string tag);
        check({tag, "_err"},   36'(err),       36'(1));
        check({tag, "_state"}, 36'(state),     36'(10));
        check({tag, "_ready"}, 36'(in_ready),  36'(0));
        check({tag, "_busy"},  36'(busy),      36'(0));
        check({tag, "_run"},   36'(accel_run), 36'(0));
        check_cfg(tag);
    endtask

    // done_delay == 0 ends the run with abort racing accel_done and job_clr.
    task automatic run_job(input string tag, input logic [17:0] dim_w, input logic [17:0] depth_w,
                           input logic [17:0] stride_w, input logic [17:0] half_w,
                           input logic [17:0] len_w, input logic [17:0] bias_w,
                           input int gap, input bit seq, input int done_delay);
        bit ok;
        load_job(dim_w, depth_w, stride_w, half_w, len_w, bias_w, gap, seq, ok);
        if (ok) begin
            check({tag, "_state_run"}, 36'(state), 36'(8));
            check({tag, "_last_wr"},   36'(wr_en), 36'(1));
            wait_run();
            check_writes(tag);
            check_cfg(tag);
            if (done_delay > 0) begin
                repeat (done_delay - 1) tick();
                accel_done = 1'b1;
                tick();
                accel_done = 1'b0;
                check({tag, "_done"},      36'(done),      36'(1));
                check({tag, "_state_done"}, 36'(state),    36'(9));
                check({tag, "_run_off"},   36'(accel_run), 36'(0));
                check({tag, "_busy_done"}, 36'(busy),      36'(0));
                clear_job();
            end else begin
                repeat ($urandom_range(0, 5)) tick();
                abort      = 1'b1;
                accel_done = 1'b1;
                job_clr    = 1'b1;
                tick();
                abort      = 1'b0;
                accel_done = 1'b0;
                job_clr    = 1'b0;
                check({tag, "_abort_state"}, 36'(state),     36'(0));
                check({tag, "_abort_run"},   36'(accel_run), 36'(0));
                check({tag, "_abort_done"},  36'(done),      36'(0));
            end
        end else begin
            finish_err(tag);
            check_writes(tag);
            clear_job();
        end
    endtask

    initial begin
        int k;
        bit ok;
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        abort      = 1'b0;
        job_clr    = 1'b0;
        accel_done = 1'b0;
        repeat (3) tick();
        check("rst_state", 36'(state), 36'(0));
        check("rst_wr_en", 36'(wr_en), 36'(0));
        check("rst_wr_addr", 36'(wr_addr), 36'(0));
        check("rst_wr_data", 36'(wr_data), 36'(0));
        check("rst_wr_sel", 36'(wr_sel), 36'(0));
        check("rst_run", 36'(accel_run), 36'(0));
        check("rst_flags", 36'({busy, done, err}), 36'(0));
        check_cfg("rst");
        rst = 1'b0;
        tick();
        check("rst_ready", 36'(in_ready), 36'(1));

        // Basic job with sequential data, done after 10 cycles of run.
        run_job("job_basic", 18'd2, 18'd1, 18'd1, 18'd1, 18'd3, 18'd5, 0, 1'b1, 10);

        // Zero dimension must error with no writes.
        run_job("job_dim0", 18'd0, 18'd3, 18'd0, 18'd0, 18'd0, 18'd0, 0, 1'b0, 1);
        check("dim0_depth_kept", 36'(image_depth), 36'(3));

        // Valid toggling every cycle: 32 contiguous image writes.
        run_job("job_toggle", 18'd4, 18'd2, 18'd3, 18'd2, 18'd2, 18'h2abcd, 1, 1'b0, 3);

        // Image size boundary: exactly MAX accepted, above MAX rejected; zero length rejected.
        run_job("job_max", 18'd8, 18'd1, 18'd2, 18'd1, 18'd1, 18'd9, 0, 1'b0, 1);
        run_job("job_over", 18'd8, 18'd2, 18'd2, 18'd1, 18'd1, 18'd9, 0, 1'b0, 1);
        run_job("job_len0", 18'd1, 18'd1, 18'd5, 18'd3, 18'd0, 18'd9, 0, 1'b0, 1);

        // Timeout: accel_done never arrives.
        load_job(18'd3, 18'd1, 18'd1, 18'd1, 18'd2, 18'd4, 2, 1'b0, ok);
        check("to_state_run", 36'(state), 36'(8));
        wait_run();
        k = 0;
        while (!err && k < 300) begin
            tick();
            k++;
        end
        check("to_cycles", 36'(k), 36'(RUN_TIMEOUT));
        check("to_run_off", 36'(accel_run), 36'(0));
        check("to_state", 36'(state), 36'(10));
        check_writes("to_wr");
        clear_job();

        // Abort with the 3rd image beat: that beat is dropped.
        send(18'd2, 0);
        send(18'd1, 0);
        m_dim   = 2;
        m_depth = 1;
        for (int i = 0; i < 2; i++) begin
            send(18'(100 + i), 0);
            exp_q.push_back({2'd0, 16'(i), 18'(100 + i)});
        end
        in_valid = 1'b1;
        in_data  = 18'd102;
        abort    = 1'b1;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        check("abort_state", 36'(state), 36'(0));
        check("abort_run", 36'(accel_run), 36'(0));
        check("abort_wr_en", 36'(wr_en), 36'(0));
        check("abort_busy", 36'(busy), 36'(0));
        tick();
        check_writes("abort_wr");
        run_job("job_after_abort", 18'd2, 18'd1, 18'd1, 18'd1, 18'd3, 18'd5, 0, 1'b1, 10);

        // Randomized jobs: upper bits of header words are noise, some jobs error or abort.
        for (int j = 0; j < 8; j++) begin
            run_job("job_rand",
                    {10'($urandom), 8'($urandom_range(0, 5))},
                    {9'($urandom), 9'($urandom_range(0, 3))},
                    18'($urandom), 18'($urandom),
                    {5'($urandom), 13'($urandom_range(0, 4))},
                    18'($urandom), 2, 1'b0, int'($urandom_range(0, 15)));
        end

        // Reset in the middle of filter loading.
        send(18'd2, 0);
        send(18'd1, 0);
        for (int i = 0; i < 4; i++) begin
            send(18'(i + 1), 0);
            exp_q.push_back({2'd0, 16'(i), 18'(i + 1)});
        end
        send(18'd1, 0);
        send(18'd1, 0);
        send(18'd3, 0);
        send(18'd5, 0);
        send(18'd7, 0);
        exp_q.push_back({2'd1, 16'd0, 18'd7});
        check("pre_rst_state", 36'(state), 36'(7));
        in_valid = 1'b1;
        in_data  = 18'd8;
        rst      = 1'b1;
        tick();
        in_valid = 1'b0;
        m_dim = 0; m_depth = 0; m_stride = 0; m_half = 0; m_len = 0; m_bias = 0;
        check("mid_rst_state", 36'(state), 36'(0));
        check("mid_rst_wr_en", 36'(wr_en), 36'(0));
        check("mid_rst_wr_addr", 36'(wr_addr), 36'(0));
        check("mid_rst_wr_data", 36'(wr_data), 36'(0));
        check("mid_rst_wr_sel", 36'(wr_sel), 36'(0));
        check("mid_rst_run", 36'(accel_run), 36'(0));
        check("mid_rst_flags", 36'({busy, done, err}), 36'(0));
        check_cfg("mid_rst");
        rst = 1'b0;
        tick();
        check("mid_rst_ready", 36'(in_ready), 36'(1));
        check_writes("mid_rst_wr");
        accel_done = 1'b1;
        tick();
        accel_done = 1'b0;
        check("idle_done_state", 36'(state), 36'(0));
        check("idle_done_flags", 36'({busy, done, err}), 36'(0));
        tick();
        check("idle_done_run", 36'(accel_run), 36'(0));

        check("no_run_during_wr", 36'(overlap), 36'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
